// File: rtl/bcd_adjust_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bcd_adjust_stage                                           |
// | Description : Registered 6502 decimal-adjust and C/Z/N/V flag stage that |
// |               follows the 8-bit adder/subtractor. Binary results are     |
// |               presented one cycle after accept; decimal results go       |
// |               through a low-nibble then a high-nibble correction cycle.  |
// |               Optional macro BCD_ADJ_DEC_NZ_EN: take N/Z from the        |
// |               adjusted decimal result (65C02) instead of the binary sum. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bcd_adjust_stage #(
  parameter logic PASS_THROUGH = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] sum,
  input  logic       cout4,
  input  logic       cout8,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic       sub,
  input  logic       dec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJ_LO = 2'd1,
    ADJ_HI = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] sum_q;
  logic       cout4_q;
  logic       cout8_q;
  logic       sub_q;
  logic [7:0] tmp_q;
  logic       tcarry_q;

  logic       accept;
  logic       v_in;
  logic       lo_adj;
  logic [8:0] tmp_full;
  logic       hi_adj;
  logic [7:0] adj_res;
  logic       adj_c;

  // In HOLD, a completing handshake frees the stage for a same-cycle accept
  // only when back-to-back operation is enabled.
  assign in_ready  = (state == IDLE) |
                     (PASS_THROUGH & (state == HOLD) & out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Signed overflow: operands of equal sign (B after the SBC inversion)
  // producing a sum of the opposite sign.
  assign v_in = (a_msb == (b_msb ^ sub)) & (sum[7] != a_msb);

  // Decimal correction arithmetic for both nibble cycles.
  always_comb begin
    lo_adj   = 1'b0;
    tmp_full = 9'd0;
    hi_adj   = 1'b0;
    adj_res  = 8'd0;
    adj_c    = 1'b0;
    if (sub_q) begin
      lo_adj   = ~cout4_q;
      tmp_full = {1'b0, sum_q - (lo_adj ? 8'h06 : 8'h00)};
      hi_adj   = ~cout8_q;
      adj_res  = tmp_q - (hi_adj ? 8'h60 : 8'h00);
      adj_c    = cout8_q;
    end else begin
      lo_adj   = cout4_q | (sum_q[3:0] > 4'd9);
      tmp_full = {1'b0, sum_q} + (lo_adj ? 9'h006 : 9'h000);
      hi_adj   = cout8_q | tcarry_q | (tmp_q[7:4] > 4'd9);
      adj_res  = tmp_q + (hi_adj ? 8'h60 : 8'h00);
      adj_c    = hi_adj;
    end
  end

  // Next-state selection; an accept in HOLD implies out_ready was high.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec ? ADJ_LO : HOLD;
      ADJ_LO:  state_nxt = ADJ_HI;
      ADJ_HI:  state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = dec ? ADJ_LO : HOLD;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture, nibble correction pipeline and result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q    <= 8'h00;
      cout4_q  <= 1'b0;
      cout8_q  <= 1'b0;
      sub_q    <= 1'b0;
      tmp_q    <= 8'h00;
      tcarry_q <= 1'b0;
      result   <= 8'h00;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
    end else if (accept) begin
      // Binary result is final here; decimal overwrites result and C later.
      sum_q    <= sum;
      cout4_q  <= cout4;
      cout8_q  <= cout8;
      sub_q    <= sub;
      result   <= sum;
      flag_c   <= cout8;
      flag_z   <= (sum == 8'h00);
      flag_n   <= sum[7];
      flag_v   <= v_in;
    end else if (state == ADJ_LO) begin
      tmp_q    <= tmp_full[7:0];
      tcarry_q <= tmp_full[8];
    end else if (state == ADJ_HI) begin
      result   <= adj_res;
      flag_c   <= adj_c;
`ifdef BCD_ADJ_DEC_NZ_EN
      flag_z   <= (adj_res == 8'h00);
      flag_n   <= adj_res[7];
`else
      // NMOS parts report N/Z of the uncorrected binary sum, kept from accept.
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/bcd_adjust_stage.md
Name: bcd_adjust_stage

Overview:
- Registered decimal-adjust and flag stage directly downstream of the 8-bit ripple adder/subtractor in the m6502 ALU path.
- Consumes the binary sum, the half-carry and the carry-out, then applies 6502 BCD correction when decimal mode is set.
- Produces the final ALU result and the C, Z, N and V flags through a valid/ready handshake.

Parameters:
- PASS_THROUGH, 0: when 1, in_ready is also high in HOLD while out_ready=1, allowing back-to-back transactions with no IDLE bubble.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operands and adder outputs valid.
- in_ready  output  1  stage can accept a transaction.
- sum  input  8  binary sum from the adder/subtractor.
- cout4  input  1  half-carry (carry out of bit 3).
- cout8  input  1  carry out of bit 7.
- a_msb  input  1  bit 7 of the A operand.
- b_msb  input  1  bit 7 of the raw B operand (before the sub XOR).
- sub  input  1  1 = SBC, 0 = ADC.
- dec  input  1  decimal mode (D flag).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts.
- result  output  8  final result.
- flag_c, flag_z, flag_n, flag_v  output  1 each  processor flags.

Behaviour:
- Single clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: IDLE. in_ready=1; out_valid=0; result=0x00; all flags 0.
- Accept: in_valid & in_ready on a rising edge latches all inputs.
- V is computed at accept in every mode: (a_msb == (b_msb^sub)) & (sum[7] != a_msb).
- States: IDLE, ADJ_LO, ADJ_HI, HOLD.
- IDLE:
  - Accept with dec=0 -> HOLD. result=sum, C=cout8, N/Z from sum. Latency 1 cycle.
  - Accept with dec=1 -> ADJ_LO.
- ADJ_LO (in_ready=0):
  - ADC: lo_adj = cout4 | (sum[3:0] > 9). tmp = sum + (lo_adj ? 0x06 : 0x00), 9-bit; tcarry = tmp[8].
  - SBC: lo_adj = ~cout4. tmp = sum - (lo_adj ? 0x06 : 0x00), 8-bit wrap; tcarry = 0.
  - Go to ADJ_HI.
- ADJ_HI (in_ready=0):
  - ADC: hi_adj = cout8 | tcarry | (tmp[7:4] > 9). result = tmp + (hi_adj ? 0x60 : 0x00), mod 256. C = hi_adj.
  - SBC: hi_adj = ~cout8. result = tmp - (hi_adj ? 0x60 : 0x00), mod 256. C = cout8.
  - Go to HOLD. Decimal latency is 3 cycles from accept to out_valid.
- HOLD:
  - out_valid=1; result and flags stable until the handshake completes.
  - out_ready=1 -> IDLE, or directly ADJ_LO/HOLD on a PASS_THROUGH back-to-back accept.
  - out_ready=0 -> remain in HOLD. Inputs are ignored unless PASS_THROUGH=1 with out_ready=1.
- N/Z in decimal mode: from the binary sum (NMOS behaviour) unless the optional feature below is enabled.
- Reset asserted in any state: return to the reset state next edge; the in-flight transaction is dropped with no out_valid pulse.
- Input changes while not accepting have no effect. in_valid may drop without acceptance (no-commit protocol).

Optional Feature:
- Macro: BCD_ADJ_DEC_NZ_EN.
- Defined: in decimal mode, N and Z are taken from the adjusted result (65C02 behaviour).
- Undefined: in decimal mode, N and Z are taken from the binary sum.
- Binary mode, C and V are unaffected either way.

Test Plan:
- Binary ADC, sum=0xA0, cout4=0, cout8=0, a_msb=0, b_msb=0, sub=0, dec=0 -> out_valid 1 cycle after accept; result=0xA0, C=0, N=1, Z=0, V=1.
- Decimal ADC 0x19+0x28: sum=0x41, cout4=1, cout8=0 -> out_valid 3 cycles after accept; result=0x47, C=0.
- Decimal ADC 0x99+0x01: sum=0x9A, cout4=0, cout8=0 -> result=0x00, C=1.
  - Without the macro: N=1, Z=0.
  - With BCD_ADJ_DEC_NZ_EN: N=0, Z=1.
- Decimal SBC 0x42-0x15 (cin=1): sum=0x2D, cout4=0, cout8=1, sub=1 -> result=0x27, C=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid, result and flags stay stable and in_ready=0. Then raise out_ready -> IDLE next edge.
  - PASS_THROUGH=1 variant: with out_ready=1 and in_valid=1, a new binary transaction is accepted in the same cycle and out_valid stays high.
- Reset asserted during ADJ_HI -> next edge: out_valid=0, result=0x00, flags 0, in_ready=1; no output is produced for the dropped transaction.
